button_event_arbiter: RTL and testbench

- Collects one-cycle active-high event pulses from NUM_CHANNELS debounced button inputs and latches each as a pending request.
- Grants pending requests one at a time in round-robin order and presents each as an event ID on a valid/ready interface to the control logic that selects MITM modes.
- Enforces a shared lockout period after every accepted event, so one button cannot flood the consumer.
- Reports lost presses through sticky per-channel overflow flags.

---
 rtl/button_event_arbiter.sv | 119 +++++++++++
 tb/tb_button_event_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter turning debounced button pulses into a stream of event IDs,
// with a shared post-accept lockout and sticky per-channel lost-press flags.
module button_event_arbiter #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned LOCKOUT_COUNT = 1_000_000
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic [NUM_CHANNELS-1:0]         in_pulse,
  output logic                            evt_valid,
  output logic [$clog2(NUM_CHANNELS)-1:0] evt_id,
  input  logic                            evt_ready,
  output logic [NUM_CHANNELS-1:0]         overflow,
  input  logic                            ovf_clear,
  output logic                            busy
);

  localparam int unsigned ID_WIDTH  = $clog2(NUM_CHANNELS);
  localparam int unsigned CTR_W     = (LOCKOUT_COUNT > 0) ? $clog2(LOCKOUT_COUNT + 1) : 1;
  localparam int unsigned LOCK_LAST = (LOCKOUT_COUNT > 0) ? LOCKOUT_COUNT - 1 : 0;

  typedef enum logic [1:0] {IDLE, OFFER, LOCKOUT} state_t;

  state_t                  state, state_nxt;
  logic [NUM_CHANNELS-1:0] pending, pending_nxt;
  logic [NUM_CHANNELS-1:0] overflow_nxt;
  logic [NUM_CHANNELS-1:0] clr_mask;
  logic [ID_WIDTH-1:0]     last_grant, last_grant_nxt;
  logic [ID_WIDTH-1:0]     evt_id_nxt;
  logic [ID_WIDTH-1:0]     sel;
  logic                    found;
  logic                    evt_valid_nxt;
  logic                    busy_nxt;
  logic [CTR_W-1:0]        lock_ctr, lock_ctr_nxt;

  // State and all outputs are registered here.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      overflow   <= '0;
      busy       <= 1'b0;
      pending    <= '0;
      last_grant <= ID_WIDTH'(NUM_CHANNELS - 1);
      lock_ctr   <= '0;
    end else begin
      state      <= state_nxt;
      evt_valid  <= evt_valid_nxt;
      evt_id     <= evt_id_nxt;
      overflow   <= overflow_nxt;
      busy       <= busy_nxt;
      pending    <= pending_nxt;
      last_grant <= last_grant_nxt;
      lock_ctr   <= lock_ctr_nxt;
    end
  end

  // Round-robin search starting just above the last granted channel.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
      logic [ID_WIDTH-1:0] idx;
      idx = ID_WIDTH'((32'(last_grant) + k) % NUM_CHANNELS);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state, grant and lockout sequencing.
  always_comb begin
    state_nxt      = state;
    evt_valid_nxt  = evt_valid;
    evt_id_nxt     = evt_id;
    last_grant_nxt = last_grant;
    lock_ctr_nxt   = lock_ctr;
    clr_mask       = '0;

    unique case (state)
      IDLE: begin
        if (found) begin
          evt_id_nxt     = sel;
          last_grant_nxt = sel;
          clr_mask       = NUM_CHANNELS'(1) << sel;
          evt_valid_nxt  = 1'b1;
          state_nxt      = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          evt_valid_nxt = 1'b0;
          lock_ctr_nxt  = '0;
          state_nxt     = (LOCKOUT_COUNT > 0) ? LOCKOUT : IDLE;
        end
      end
      LOCKOUT: begin
        if (lock_ctr == CTR_W'(LOCK_LAST)) begin
          lock_ctr_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          lock_ctr_nxt = lock_ctr + CTR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // A new pulse always re-arms pending; it only counts as lost if the bit was already held.
  always_comb begin
    pending_nxt  = (pending & ~clr_mask) | in_pulse;
    overflow_nxt = (ovf_clear ? '0 : overflow) | (in_pulse & pending & ~clr_mask);
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: one instance with a 4-cycle lockout,
// one with lockout disabled; delivered event IDs are checked against scoreboards.
module tb_button_event_arbiter;

  logic       sys_clk;
  logic       sys_rst;
  logic [3:0] in_pulse;
  logic       evt_ready;
  logic       ovf_clear;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] overflow;
  logic       busy;

  logic [3:0] z_pulse;
  logic       z_ready;
  logic       z_ovf_clear;
  logic       z_valid;
  logic [1:0] z_id;
  logic [3:0] z_overflow;
  logic       z_busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int z_q[$];

  button_event_arbiter #(.NUM_CHANNELS(4), .LOCKOUT_COUNT(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_pulse(in_pulse),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .overflow(overflow), .ovf_clear(ovf_clear), .busy(busy)
  );

  button_event_arbiter #(.NUM_CHANNELS(4), .LOCKOUT_COUNT(0)) dut_z (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_pulse(z_pulse),
    .evt_valid(z_valid), .evt_id(z_id), .evt_ready(z_ready),
    .overflow(z_overflow), .ovf_clear(z_ovf_clear), .busy(z_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && !(exp_q.size() == 0 && !busy && !evt_valid); i++) step();
    chk("drain_queue", 32'(exp_q.size()), 0);
    chk("drain_busy", 32'(busy), 0);
  endtask

  // Handshake monitors: inputs are stable across the falling edge, so valid&&ready here
  // means the following rising edge accepts the event.
  always @(negedge sys_clk) begin
    if (!sys_rst && evt_valid && evt_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL evt_unexpected observed=%0d expected=none", evt_id);
      end
      if (exp_q.size() > 0) chk("evt_order", 32'(evt_id), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge sys_clk) begin
    if (!sys_rst && z_valid && z_ready) begin
      n_cmp++;
      assert (z_q.size() > 0) else begin
        n_err++;
        $error("FAIL z_evt_unexpected observed=%0d expected=none", z_id);
      end
      if (z_q.size() > 0) chk("z_evt_order", 32'(z_id), 32'(z_q.pop_front()));
    end
  end

  initial begin
    sys_rst     = 1'b0;
    in_pulse    = '0;
    evt_ready   = 1'b0;
    ovf_clear   = 1'b0;
    z_pulse     = '0;
    z_ready     = 1'b1;
    z_ovf_clear = 1'b0;

    // Reset values
    #1 sys_rst = 1'b1;
    #1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    step();
    step();
    sys_rst = 1'b0;
    step();

    // Single press on ch2 with ready held high
    evt_ready = 1'b1;
    in_pulse  = 4'b0100;
    exp_q.push_back(2);
    step();                                   // E0
    in_pulse = '0;
    chk("single_e0_valid", 32'(evt_valid), 0);
    step();                                   // E1
    chk("single_e1_valid", 32'(evt_valid), 1);
    chk("single_e1_id", 32'(evt_id), 2);
    chk("single_e1_busy", 32'(busy), 1);
    step();                                   // E2 handshake
    chk("single_e2_valid", 32'(evt_valid), 0);
    chk("single_e2_busy", 32'(busy), 1);
    step(); step(); step();                   // E5
    chk("single_e5_busy", 32'(busy), 1);
    step();                                   // E6
    chk("single_e6_busy", 32'(busy), 0);

    // Simultaneous pulses from reset: order 0,1,3 with lockout spacing
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    step();
    in_pulse = 4'b1011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    step();                                   // E0
    in_pulse = '0;
    step();                                   // E1
    chk("simul_e1_id", 32'(evt_id), 0);
    chk("simul_e1_valid", 32'(evt_valid), 1);
    for (int i = 0; i < 5; i++) step();       // E6
    chk("simul_e6_valid", 32'(evt_valid), 0);
    step();                                   // E7
    chk("simul_e7_valid", 32'(evt_valid), 1);
    chk("simul_e7_id", 32'(evt_id), 1);
    for (int i = 0; i < 5; i++) step();       // E12
    chk("simul_e12_valid", 32'(evt_valid), 0);
    step();                                   // E13
    chk("simul_e13_valid", 32'(evt_valid), 1);
    chk("simul_e13_id", 32'(evt_id), 3);
    drain(100);
    chk("simul_overflow", 32'(overflow), 0);

    // Round-robin: after a ch1 grant, ch3 beats ch0
    in_pulse = 4'b0010;
    exp_q.push_back(1);
    step();
    in_pulse = '0;
    drain(100);
    in_pulse = 4'b1001;
    exp_q.push_back(3);
    exp_q.push_back(0);
    step();
    in_pulse = '0;
    step();
    chk("rr_first_id", 32'(evt_id), 3);
    drain(100);

    // Backpressure and overflow on ch1
    evt_ready = 1'b0;
    in_pulse  = 4'b0010;
    exp_q.push_back(1);
    step();                                   // latch
    in_pulse = '0;
    step();                                   // grant
    chk("bp_valid", 32'(evt_valid), 1);
    chk("bp_id", 32'(evt_id), 1);
    in_pulse = 4'b0010;
    exp_q.push_back(1);
    step();                                   // pending[1] set again
    chk("bp_no_ovf_yet", 32'(overflow), 0);
    step();                                   // lost press
    in_pulse = '0;
    step();
    chk("bp_id_held", 32'(evt_id), 1);
    chk("bp_valid_held", 32'(evt_valid), 1);
    chk("bp_overflow", 32'(overflow), 32'(4'b0010));
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    in_pulse  = 4'b0010;
    ovf_clear = 1'b1;
    step();
    in_pulse  = '0;
    ovf_clear = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'(4'b0010));
    evt_ready = 1'b1;
    drain(100);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;

    // Zero lockout with grant/pulse collision on ch2
    z_pulse = 4'b0100;
    z_q.push_back(2);
    step();                                   // E0 latch
    z_q.push_back(2);
    step();                                   // E1 grant + new pulse
    z_pulse = '0;
    chk("z_e1_valid", 32'(z_valid), 1);
    chk("z_e1_id", 32'(z_id), 2);
    chk("z_e1_overflow", 32'(z_overflow), 0);
    step();                                   // E2 handshake
    chk("z_e2_valid", 32'(z_valid), 0);
    step();                                   // E3 regrant
    chk("z_e3_valid", 32'(z_valid), 1);
    chk("z_e3_id", 32'(z_id), 2);
    step(); step();
    chk("z_queue", 32'(z_q.size()), 0);
    chk("z_busy", 32'(z_busy), 0);
    chk("z_overflow", 32'(z_overflow), 0);

    // Asynchronous reset during OFFER with ch0 and ch3 pending
    evt_ready = 1'b0;
    in_pulse  = 4'b0001;
    exp_q.push_back(0);
    step();
    in_pulse = 4'b1001;
    step();
    in_pulse = '0;
    chk("mid_valid", 32'(evt_valid), 1);
    chk("mid_id", 32'(evt_id), 0);
    chk("mid_overflow", 32'(overflow), 0);
    #3 sys_rst = 1'b1;
    #1;
    chk("async_valid", 32'(evt_valid), 0);
    chk("async_id", 32'(evt_id), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_overflow", 32'(overflow), 0);
    exp_q.delete();
    step();
    sys_rst   = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_rst_valid", 32'(evt_valid), 0);
    end
    chk("post_rst_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
